vc_elastic_buffer: RTL and testbench

- Multi-virtual-channel input buffer for the NoC router; successor of the single-channel 10-bit elastic buffer.
- Holds NUM_VC independent FIFOs of DEPTH flits each. Full depth is usable.
- Accepts flits tagged with a VC id through a valid/ready handshake.
- Drains them through one round-robin-arbitrated valid/ready output, first-word-fall-through.

---
 rtl/vc_elastic_buffer.sv | 198 +++++++++++++++++++
 tb/tb_vc_elastic_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_elastic_buffer.sv
// vc_elastic_buffer
// Multi-virtual-channel input buffer for a NoC router port. Each of NUM_VC
// channels owns an independent FIFO of DEPTH = 2**ADDR_W flits, and the full
// depth of every FIFO is usable. Flits enter through a valid/ready handshake
// tagged with a VC id. They leave through a single first-word-fall-through
// valid/ready output that is shared round-robin between the non-empty
// channels.
//
// Optional feature: define VC_BUFFER_OVF_FLAG_EN to add the sticky ovf_err
// output. It records any attempt to push to a full VC or to a VC id that does
// not exist.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   in_valid     upstream flit valid
//   in_vc        target VC of the incoming flit
//   in_data      incoming flit
//   in_ready     per-VC "not full" (bit v is VC v)
//   out_valid    output flit valid
//   out_vc       VC of the output flit
//   out_data     output flit (head of the selected VC)
//   out_ready    downstream accepts the output flit
//   almost_full  per-VC occupancy >= AF_LEVEL
//   vc_count     per-VC occupancy, VC v in [v*(ADDR_W+1) +: ADDR_W+1]
//   ovf_err      (VC_BUFFER_OVF_FLAG_EN only) sticky dropped-flit flag
module vc_elastic_buffer #(
    parameter int FLIT_W   = 10,
    parameter int ADDR_W   = 4,
    parameter int NUM_VC   = 2,
    parameter int VC_W     = 1,
    parameter int AF_LEVEL = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [VC_W-1:0]              in_vc,
    input  logic [FLIT_W-1:0]            in_data,
    output logic [NUM_VC-1:0]            in_ready,
    output logic                         out_valid,
    output logic [VC_W-1:0]              out_vc,
    output logic [FLIT_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [NUM_VC-1:0]            almost_full,
    output logic [NUM_VC*(ADDR_W+1)-1:0] vc_count
`ifdef VC_BUFFER_OVF_FLAG_EN
    ,
    output logic                         ovf_err
`endif
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    // Storage is deliberately left out of reset; the pointers alone define
    // which entries hold valid flits.
    logic [FLIT_W-1:0] r_mem [NUM_VC][DEPTH];

    // One extra pointer bit tells a full FIFO apart from an empty one.
    logic [PW-1:0]     r_wptr [NUM_VC];
    logic [PW-1:0]     r_rptr [NUM_VC];
    logic [VC_W-1:0]   r_rrPtr;
    logic              r_lock;
    logic [VC_W-1:0]   r_lockVc;

    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_full;
    logic [PW-1:0]     w_count [NUM_VC];
    logic              w_inVcOk;
    logic              w_tgtFull;
    logic              w_push;
    logic              w_pop;
    logic              w_found;
    logic [VC_W-1:0]   w_selVc;
    logic [VC_W-1:0]   w_scanIdx;
    logic [VC_W-1:0]   w_rrNext;
    logic [ADDR_W-1:0] w_rdAddr;

    // Per-VC status, all derived from the registered pointers only.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_empty[v]  = (r_wptr[v] == r_rptr[v]);
            w_full[v]   = (r_wptr[v][ADDR_W-1:0] == r_rptr[v][ADDR_W-1:0]) &&
                          (r_wptr[v][ADDR_W] != r_rptr[v][ADDR_W]);
            w_count[v]  = r_wptr[v] - r_rptr[v];
            in_ready[v] = !w_full[v];
            almost_full[v] = (w_count[v] >= AF_THRESH);
            vc_count[v*PW +: PW] = w_count[v];
        end
    end

    // Target-VC fullness is looked up by comparison so that an out-of-range
    // VC id never indexes past the end of the status vector.
    always_comb begin
        w_inVcOk  = (int'(in_vc) < NUM_VC);
        w_tgtFull = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (in_vc == VC_W'(v)) begin
                w_tgtFull = w_full[v];
            end
        end
        w_push = in_valid && w_inVcOk && !w_tgtFull;
    end

    // Output selection. A stalled flit keeps its VC through the lock so the
    // output stays stable until it is accepted. Otherwise the scan starts at
    // the round-robin pointer and picks the first non-empty VC.
    always_comb begin
        w_selVc   = '0;
        w_found   = 1'b0;
        w_scanIdx = '0;
        if (r_lock) begin
            w_selVc = r_lockVc;
            w_found = !w_empty[r_lockVc];
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                w_scanIdx = VC_W'((int'(r_rrPtr) + k) % NUM_VC);
                if (!w_found && !w_empty[w_scanIdx]) begin
                    w_selVc = w_scanIdx;
                    w_found = 1'b1;
                end
            end
        end
        w_rdAddr = r_rptr[w_selVc][ADDR_W-1:0];
        w_rrNext = VC_W'((int'(w_selVc) + 1) % NUM_VC);
        w_pop    = w_found && out_ready;
    end

    // Output drive; idle outputs are forced to zero.
    always_comb begin
        out_valid = w_found;
        out_vc    = w_found ? w_selVc : '0;
        out_data  = w_found ? r_mem[w_selVc][w_rdAddr] : '0;
    end

    // Flit storage write.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_push && (in_vc == VC_W'(v))) begin
                r_mem[v][r_wptr[v][ADDR_W-1:0]] <= in_data;
            end
        end
    end

    // Pointer update. A push and a pop on the same VC both take effect, which
    // leaves its occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wptr[v] <= '0;
                r_rptr[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push && (in_vc == VC_W'(v))) begin
                    r_wptr[v] <= r_wptr[v] + PTR_ONE;
                end
                if (w_pop && (w_selVc == VC_W'(v))) begin
                    r_rptr[v] <= r_rptr[v] + PTR_ONE;
                end
            end
        end
    end

    // Arbitration state. The round-robin pointer moves past the VC just
    // served. The lock holds the selection while the downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr  <= '0;
            r_lock   <= 1'b0;
            r_lockVc <= '0;
        end else if (w_pop) begin
            r_rrPtr <= w_rrNext;
            r_lock  <= 1'b0;
        end else if (w_found && !out_ready) begin
            r_lock   <= 1'b1;
            r_lockVc <= w_selVc;
        end
    end

`ifdef VC_BUFFER_OVF_FLAG_EN
    logic r_ovfErr;

    // Sticky record of any flit that was offered but had to be dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovfErr <= 1'b0;
        end else if (in_valid && (!w_inVcOk || w_tgtFull)) begin
            r_ovfErr <= 1'b1;
        end
    end

    assign ovf_err = r_ovfErr;
`endif

endmodule

// File: tb/tb_vc_elastic_buffer.sv
// tb_vc_elastic_buffer
// Directed and randomized bench for vc_elastic_buffer. The bench keeps one
// queue per VC as its reference. Expected outputs come from those queues
// together with the round-robin and stall-hold rules of the buffer.
module tb_vc_elastic_buffer;

    localparam int FLIT_W = 10;
    localparam int ADDR_W = 4;
    localparam int NUM_VC = 2;
    localparam int VC_W   = 1;
    localparam int AF_LEVEL = 14;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PW     = ADDR_W + 1;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic [VC_W-1:0]          in_vc;
    logic [FLIT_W-1:0]        in_data;
    logic [NUM_VC-1:0]        in_ready;
    logic                     out_valid;
    logic [VC_W-1:0]          out_vc;
    logic [FLIT_W-1:0]        out_data;
    logic                     out_ready;
    logic [NUM_VC-1:0]        almost_full;
    logic [NUM_VC*PW-1:0]     vc_count;
`ifdef VC_BUFFER_OVF_FLAG_EN
    logic                     ovf_err;
`endif

    int checks = 0;
    int failures = 0;
    string stepName = "init";

    // Reference state.
    logic [FLIT_W-1:0] mq [NUM_VC][$];
    int   mRr = 0;
    bit   mLock = 0;
    int   mLockVc = 0;
    bit   mOvf = 0;

    vc_elastic_buffer #(
        .FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .NUM_VC(NUM_VC),
        .VC_W(VC_W), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_vc(in_vc),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_vc(out_vc),
        .out_data(out_data),
        .out_ready(out_ready),
        .almost_full(almost_full),
        .vc_count(vc_count)
`ifdef VC_BUFFER_OVF_FLAG_EN
        ,
        .ovf_err(ovf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", stepName, tag, obs, exp);
        end
    endtask

    // Which VC the reference expects on the output, and whether it is valid.
    task automatic modelSelect(output int sel, output bit valid);
        sel = 0;
        valid = 0;
        if (mLock) begin
            sel = mLockVc;
            valid = (mq[mLockVc].size() != 0);
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                int idx;
                idx = (mRr + k) % NUM_VC;
                if (!valid && mq[idx].size() != 0) begin
                    sel = idx;
                    valid = 1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        int sel;
        bit valid;
        logic [NUM_VC-1:0] expReady;
        logic [NUM_VC-1:0] expAf;
        logic [NUM_VC*PW-1:0] expCount;
        modelSelect(sel, valid);
        for (int v = 0; v < NUM_VC; v++) begin
            expReady[v] = (mq[v].size() < DEPTH);
            expAf[v] = (mq[v].size() >= AF_LEVEL);
            expCount[v*PW +: PW] = PW'(mq[v].size());
        end
        check("out_valid", 32'(out_valid), 32'(valid));
        check("out_vc", 32'(out_vc), valid ? 32'(sel) : 32'd0);
        check("out_data", 32'(out_data), valid ? 32'(mq[sel][0]) : 32'd0);
        check("in_ready", 32'(in_ready), 32'(expReady));
        check("almost_full", 32'(almost_full), 32'(expAf));
        check("vc_count", 32'(vc_count), 32'(expCount));
`ifdef VC_BUFFER_OVF_FLAG_EN
        check("ovf_err", 32'(ovf_err), 32'(mOvf));
`endif
    endtask

    task automatic modelReset();
        for (int v = 0; v < NUM_VC; v++) mq[v].delete();
        mRr = 0;
        mLock = 0;
        mLockVc = 0;
        mOvf = 0;
    endtask

    // One clock cycle: drive inputs, check the pre-edge outputs, clock, then
    // advance the reference by the same rules.
    task automatic applyStimulus(input logic v, input logic [VC_W-1:0] vc,
                                 input logic [FLIT_W-1:0] d, input logic rdy);
        int sel;
        bit valid;
        bit pushOk;
        bit popOk;
        bit badVc;
        in_valid = v;
        in_vc = vc;
        in_data = d;
        out_ready = rdy;
        #1;
        checkOutput();
        modelSelect(sel, valid);
        badVc = (int'(vc) >= NUM_VC);
        pushOk = v && !badVc && (mq[vc].size() < DEPTH);
        popOk = valid && rdy;
        @(posedge clk);
        #1;
        if (v && !pushOk) mOvf = 1;
        if (popOk) begin
            void'(mq[sel].pop_front());
            mRr = (sel + 1) % NUM_VC;
            mLock = 0;
        end else if (valid) begin
            mLock = 1;
            mLockVc = sel;
        end
        if (pushOk) mq[vc].push_back(d);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_vc = '0;
        in_data = '0;
        out_ready = 1'b0;
        modelReset();
        #12;
        stepName = "reset";
        checkOutput();
        check("reset_in_ready", 32'(in_ready), 32'h3);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single flit through an empty buffer.
        stepName = "single";
        applyStimulus(1'b1, 1'b0, 10'h007, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h007);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        check("single_gone", 32'(out_valid), 32'd0);

        // Fill VC1 to full, overflow once, then drain in order.
        stepName = "fill_vc1";
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, FLIT_W'(10'h100 + i), 1'b0);
        check("vc1_full_ready", 32'(in_ready), 32'h1);
        check("vc1_count", 32'(vc_count[PW +: PW]), 32'd16);
        check("vc1_af", 32'(almost_full[1]), 32'd1);
        applyStimulus(1'b1, 1'b1, 10'h3FF, 1'b0);
        stepName = "drain_vc1";
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(out_data), 32'(10'h100 + i));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        idle(1, 1'b1);

        // Round robin between two loaded VCs.
        stepName = "round_robin";
        applyStimulus(1'b1, 1'b0, 10'h0A0, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'h0A1, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'h0B0, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'h0B1, 1'b0);
        check("rr_first", 32'(out_data), 32'h0A0);
        idle(5, 1'b1);

        // Stall hold on VC1 while VC0 receives a flit.
        stepName = "stall";
        applyStimulus(1'b1, 1'b1, 10'h155, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'h0AA, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        check("stall_vc", 32'(out_vc), 32'd1);
        check("stall_data", 32'(out_data), 32'h155);
        idle(3, 1'b1);

        // Full VC0 with a pop in the same cycle refuses the push.
        stepName = "full_pop";
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, FLIT_W'(10'h200 + i), 1'b0);
        applyStimulus(1'b1, 1'b0, 10'h2AA, 1'b1);
        check("full_pop_count", 32'(vc_count[0 +: PW]), 32'd15);
        applyStimulus(1'b1, 1'b0, 10'h2AA, 1'b0);
        check("retry_count", 32'(vc_count[0 +: PW]), 32'd16);

        // Asynchronous reset between edges.
        stepName = "async_reset";
        idle(11, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, FLIT_W'(i), 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        check("areset_count", 32'(vc_count), 32'd0);
        #2;
        reset = 1'b0;

        // Randomized traffic.
        stepName = "random";
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), VC_W'($urandom),
                          FLIT_W'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), VC_W'($urandom),
                          FLIT_W'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        stepName = "final_drain";
        idle(40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
